mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 128 x 32 word memory between the convolution circuit and a second agent (host loader / result dumper). Sits between the requesters and the memory's `mem_index` / `mem_in` / `mem_wr` / `mem_out` port. Grants are registered, with round-robin priority and a bounded burst length, so neither side can starve the other.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port word memory.
// Registered grants, bounded bursts, combinational address/data mux onto the memory port.
module mem_port_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] idx0,
  input  logic [ADDR_W-1:0] idx1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_index,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  // state | meaning
  // IDLE  | no grant, port parked at index 0 with write disabled
  // G0    | requester 0 owns the port
  // G1    | requester 1 owns the port
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             xfer0, xfer1;
  logic             burst_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt0       = (state_q == G0);
  assign gnt1       = (state_q == G1);
  assign busy       = gnt0 | gnt1;
  assign xfer0      = gnt0 & req0;
  assign xfer1      = gnt1 & req1;
  assign burst_done = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? G0 : G1;
        else if (req0)     state_d = G0;
        else if (req1)     state_d = G1;
      end
      G0: begin
        if (!req0)                   state_d = req1 ? G1 : IDLE;
        else if (burst_done && req1) state_d = G1;
      end
      G1: begin
        if (!req1)                   state_d = req0 ? G0 : IDLE;
        else if (burst_done && req0) state_d = G0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count restarts on any grant change; saturates so a sole requester can hold indefinitely.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == G0) last_d = 1'b0;
      if (state_d == G1) last_d = 1'b1;
    end else if ((xfer0 || xfer1) && !burst_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    mem_index = '0;
    mem_in    = '0;
    mem_wr    = 1'b0;
    if (xfer0) begin
      mem_index = idx0;
      mem_in    = wdata0;
      mem_wr    = wr0;
    end else if (xfer1) begin
      mem_index = idx1;
      mem_in    = wdata1;
      mem_wr    = wr1;
    end
  end

  assign rdata0 = gnt0 ? mem_out : '0;
  assign rdata1 = gnt1 ? mem_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 128 x 32 memory on the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [6:0]  idx0, idx1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, mem_wr, busy;
  logic [31:0] rdata0, rdata1, mem_in, mem_out;
  logic [6:0]  mem_index;

  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_idx]   <= pre_data;
    else if (mem_wr) mem[mem_index] <= mem_in;
  end
  assign mem_out = mem[mem_index];

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .idx0(idx0), .idx1(idx1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_index(mem_index), .mem_in(mem_in), .mem_wr(mem_wr),
    .mem_out(mem_out), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    idx0 = '0; idx1 = '0; wdata0 = '0; wdata1 = '0;
    pre_we = 0; pre_idx = '0; pre_data = '0;
    #3;
    check_eq("rst_gnt0",  32'(gnt0), 32'd0);
    check_eq("rst_gnt1",  32'(gnt1), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_index", 32'(mem_index), 32'd0);
    check_eq("rst_mem_in", mem_in, 32'd0);
    check_eq("rst_rdata0", rdata0, 32'd0);
    check_eq("rst_rdata1", rdata1, 32'd0);

    pre_we = 1; pre_idx = 7'd5; pre_data = 32'hDEADBEEF;
    step();
    pre_idx = 7'd9; pre_data = 32'hA5A5A5A5;
    step();
    pre_we = 0;
    rst = 1'b0;

    // single read by requester 1
    req1 = 1; wr1 = 0; idx1 = 7'd5;
    #1 check_eq("rd_gnt1_pre", 32'(gnt1), 32'd0);
    step();
    #1;
    check_eq("rd_gnt1", 32'(gnt1), 32'd1);
    check_eq("rd_rdata1", rdata1, 32'hDEADBEEF);
    check_eq("rd_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rd_rdata0", rdata0, 32'd0);
    check_eq("rd_index", 32'(mem_index), 32'd5);
    check_eq("rd_busy", 32'(busy), 32'd1);
    req1 = 0;
    #1 check_eq("rel_index", 32'(mem_index), 32'd0);
    step();
    #1 check_eq("rel_gnt1", 32'(gnt1), 32'd0);

    // write then read by requester 0
    req0 = 1; wr0 = 1; idx0 = 7'd3; wdata0 = 32'h12345678;
    step();
    #1;
    check_eq("wr_gnt0", 32'(gnt0), 32'd1);
    check_eq("wr_mem_wr", 32'(mem_wr), 32'd1);
    check_eq("wr_index", 32'(mem_index), 32'd3);
    check_eq("wr_mem_in", mem_in, 32'h12345678);
    step();
    wr0 = 0;
    #1;
    check_eq("rbk_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rbk_rdata0", rdata0, 32'h12345678);
    req0 = 0;
    step();
    step();

    // tie after reset, then sustained contention: 9 cycles per turn
    rst = 1'b1;
    #2 rst = 1'b0;
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; idx0 = 7'd1; idx1 = 7'd2;
    for (int i = 0; i < 36; i++) begin
      step();
      #1;
      check_eq($sformatf("cont_gnt_%0d", i), 32'({gnt1, gnt0}),
               ((i / 9) % 2 == 0) ? 32'd1 : 32'd2);
      check_eq($sformatf("cont_idx_%0d", i), 32'(mem_index),
               ((i / 9) % 2 == 0) ? 32'd1 : 32'd2);
    end
    req0 = 0; req1 = 0;
    step();
    step();
    check_eq("cont_idle", 32'(busy), 32'd0);

    // sole requester keeps the port; a late peer takes over at the next edge
    req0 = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      check_eq($sformatf("sole_gnt_%0d", i), 32'({gnt1, gnt0}),
               (i <= 12) ? 32'd1 : 32'd2);
      if (i == 12) req1 = 1;
    end
    req0 = 0; req1 = 0;
    step();
    step();

    // reset during a G1 write cycle
    req1 = 1; wr1 = 1; idx1 = 7'd9; wdata1 = 32'h00005555;
    step();
    #1 check_eq("mid_mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_gnt1", 32'(gnt1), 32'd0);
    check_eq("mid_mem_wr_rst", 32'(mem_wr), 32'd0);
    step();
    check_eq("mid_word", mem[9], 32'hA5A5A5A5);
    rst = 1'b0;
    wr1 = 0; req0 = 1; req1 = 1;
    step();
    #1;
    check_eq("post_tie_gnt0", 32'(gnt0), 32'd1);
    check_eq("post_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 0; req1 = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
